// File: rtl/alu4_issue_q.sv
// Operation FIFO feeding an external combinational 4-bit ALU, with a single
// registered result slot handed downstream over valid/ready.
module alu4_issue_q #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_a,
    input  logic [3:0]             in_b,
    input  logic [2:0]             in_op,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_op,
    input  logic [3:0]             alu_r,
    input  logic                   alu_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_r,
    output logic                   out_zero,
    output logic [2:0]             out_op,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             ops_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_t;

    logic [10:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [10:0]   head_p0;
    logic          nonempty;
    logic          slot_free;
    logic          push;
    logic          pop;

    slot_t         slot_p1;
    logic [3:0]    r_p1;
    logic          zero_p1;
    logic [2:0]    op_p1;
    logic [7:0]    done_p1;

    // Stage 0: FIFO head drives the ALU; handshake decisions use registered state only
    assign nonempty  = (cnt != '0);
    assign in_ready  = (cnt < CW'(DEPTH));
    assign slot_free = (slot_p1 == SLOT_EMPTY) | out_ready;
    assign push      = in_valid & in_ready;
    assign pop       = nonempty & slot_free;

    assign head_p0 = mem[rd_ptr];
    assign alu_a   = nonempty ? head_p0[10:7] : 4'd0;
    assign alu_b   = nonempty ? head_p0[6:3]  : 4'd0;
    assign alu_op  = nonempty ? head_p0[2:0]  : 3'd0;

    // Storage carries no reset; stale entries are never visible once pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_op};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Stage 1: result slot captures the ALU output at the edge the head advances
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_p1 <= SLOT_EMPTY;
            r_p1    <= 4'd0;
            zero_p1 <= 1'b0;
            op_p1   <= 3'd0;
            done_p1 <= 8'd0;
        end else begin
            if (pop) begin
                r_p1    <= alu_r;
                zero_p1 <= alu_zero;
                op_p1   <= head_p0[2:0];
                done_p1 <= done_p1 + 8'd1;
            end
            case (slot_p1)
                SLOT_EMPTY: if (pop) slot_p1 <= SLOT_FULL;
                SLOT_FULL:  if (out_ready && !pop) slot_p1 <= SLOT_EMPTY;
                default:    slot_p1 <= SLOT_EMPTY;
            endcase
        end
    end

    assign out_valid = (slot_p1 == SLOT_FULL);
    assign out_r     = r_p1;
    assign out_zero  = zero_p1;
    assign out_op    = op_p1;
    assign count     = cnt;
    assign ops_done  = done_p1;

endmodule

// File: tb/tb_alu4_issue_q.sv
// Scoreboard bench for alu4_issue_q with a behavioural ALU stub on the alu_* ports.
module tb_alu4_issue_q;

    typedef struct packed {
        logic [3:0] r;
        logic       z;
        logic [2:0] op;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_r;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_r;
    logic       out_zero;
    logic [2:0] out_op;
    logic [2:0] count;
    logic [7:0] ops_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    alu4_issue_q #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_zero(out_zero), .out_op(out_op),
        .count(count), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // ALU stub: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 less-than, 7 pass B
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return 4'(a + b);
            3'd1:    return 4'(a - b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return (a < b) ? 4'd1 : 4'd0;
            default: return b;
        endcase
    endfunction

    function automatic res_t exp_of(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [3:0] r;
        r = alu_f(a, b, op);
        return '{r: r, z: (r == 4'd0), op: op};
    endfunction

    always_comb begin
        alu_r    = alu_f(alu_a, alu_b, alu_op);
        alu_zero = (alu_r == 4'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_a = 4'd7; in_b = 4'd1; in_op = 3'd0; out_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if ({out_r, out_zero, out_op} !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got r=%0d z=%b op=%0d want 0", out_r, out_zero, out_op); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (ops_done !== 8'd0) begin n_fail++; $display("FAIL reset_ops_done got %0d want 0", ops_done); end
        n_checks++; if ({alu_a, alu_b, alu_op} !== 11'd0) begin n_fail++; $display("FAIL reset_alu_in got a=%0d b=%0d op=%0d want 0", alu_a, alu_b, alu_op); end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_push got count=%0d out_valid=%b want 0/0", count, out_valid); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd2; in_op = 3'd0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if ({alu_a, alu_b, alu_op} !== {4'd3, 4'd2, 3'd0}) begin n_fail++; $display("FAIL single_head got a=%0d b=%0d op=%0d want 3 2 0", alu_a, alu_b, alu_op); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got out_valid=%b want 0", out_valid); end
        tick();
        n_checks++; if ({out_valid, out_r, out_zero, out_op} !== {1'b1, 4'd5, 1'b0, 3'd0}) begin n_fail++; $display("FAIL single_result got v=%b r=%0d z=%b op=%0d want 1 5 0 0", out_valid, out_r, out_zero, out_op); end
        n_checks++; if (ops_done !== 8'd1 || count !== 3'd0) begin n_fail++; $display("FAIL single_counters got ops_done=%0d count=%0d want 1 0", ops_done, count); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_r !== 4'd5) begin n_fail++; $display("FAIL single_release got v=%b r=%0d want 0 5", out_valid, out_r); end
        n_checks++; if ({alu_a, alu_b, alu_op} !== 11'd0) begin n_fail++; $display("FAIL single_empty_alu got a=%0d b=%0d op=%0d want 0", alu_a, alu_b, alu_op); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ops [3];
        res_t        want [3];
        int          k = 0;
        ops[0] = {4'd5, 4'd5, 3'd1};
        ops[1] = {4'b1010, 4'b0101, 3'd2};
        ops[2] = {4'b1000, 4'b0010, 3'd3};
        want[0] = '{r: 4'd0,  z: 1'b1, op: 3'd1};
        want[1] = '{r: 4'd0,  z: 1'b1, op: 3'd2};
        want[2] = '{r: 4'd10, z: 1'b0, op: 3'd3};
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 3);
            if (c < 3) {in_a, in_b, in_op} = ops[c];
            if (in_valid && in_ready) exp_q.push_back(want[c]);
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra got r=%0d op=%0d with nothing expected", out_r, out_op);
                end else begin
                    if ({out_r, out_zero, out_op} !== exp_q[0] || c != 2 + k) begin
                        n_fail++;
                        $display("FAIL b2b_result%0d got r=%0d z=%b op=%0d cyc=%0d want r=%0d z=%b op=%0d cyc=%0d",
                                 k, out_r, out_zero, out_op, c, exp_q[0].r, exp_q[0].z, exp_q[0].op, 2 + k);
                    end
                    void'(exp_q.pop_front());
                end
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (k != 3) begin n_fail++; $display("FAIL b2b_count got %0d results want 3", k); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_a = 4'(i + 1); in_b = 4'(2 * i); in_op = 3'(i % 4);
            if (in_ready) begin
                accepted++;
                exp_q.push_back(exp_of(in_a, in_b, in_op));
            end
            if (i >= 2) begin
                n_checks++;
                if ({out_valid, out_r, out_zero, out_op} !== {1'b1, exp_q[0]}) begin
                    n_fail++; $display("FAIL bp_hold cyc%0d got v=%b r=%0d op=%0d want 1 r=%0d op=%0d", i, out_valid, out_r, out_op, exp_q[0].r, exp_q[0].op);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (accepted != 5) begin n_fail++; $display("FAIL bp_accepted got %0d want 5", accepted); end
        n_checks++; if (in_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL bp_full got in_ready=%b count=%0d want 0 4", in_ready, count); end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                n_checks++;
                if ({out_r, out_zero, out_op} !== exp_q[0]) begin
                    n_fail++; $display("FAIL bp_drain got r=%0d z=%b op=%0d want r=%0d z=%b op=%0d", out_r, out_zero, out_op, exp_q[0].r, exp_q[0].z, exp_q[0].op);
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain_timeout got %0d left want 0", exp_q.size()); exp_q.delete(); end
        n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL bp_empty got v=%b count=%0d want 0 0", out_valid, count); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 4'(9 + i); in_b = 4'(i); in_op = 3'(4 + (i % 3));
            if (in_ready) exp_q.push_back(exp_of(in_a, in_b, in_op));
            tick();
        end
        n_checks++; if (in_ready !== 1'b0 || count !== 3'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_setup got in_ready=%b count=%0d v=%b want 0 4 1", in_ready, count, out_valid); end
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_op = 3'd0; out_ready = 1'b1;
        n_checks++;
        if ({out_r, out_zero, out_op} !== exp_q[0]) begin
            n_fail++; $display("FAIL fpp_first got r=%0d op=%0d want r=%0d op=%0d", out_r, out_op, exp_q[0].r, exp_q[0].op);
        end
        void'(exp_q.pop_front());
        tick();
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fpp_reject got count=%0d in_ready=%b want 3 1", count, in_ready); end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                n_checks++;
                if ({out_r, out_zero, out_op} !== exp_q[0]) begin
                    n_fail++; $display("FAIL fpp_drain got r=%0d z=%b op=%0d want r=%0d z=%b op=%0d", out_r, out_zero, out_op, exp_q[0].r, exp_q[0].z, exp_q[0].op);
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        n_checks++; if (exp_q.size() != 0 || out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL fpp_end got left=%0d v=%b count=%0d want 0 0 0", exp_q.size(), out_valid, count); exp_q.delete(); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            in_valid  = (c < 150) && ($urandom_range(0, 3) != 0);
            out_ready = (c >= 150) || ($urandom_range(0, 2) != 0);
            in_a = 4'($urandom); in_b = 4'($urandom); in_op = 3'($urandom);
            if (in_valid && in_ready) exp_q.push_back(exp_of(in_a, in_b, in_op));
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra got r=%0d op=%0d with nothing expected", out_r, out_op);
                end else begin
                    if ({out_r, out_zero, out_op} !== exp_q[0]) begin
                        n_fail++; $display("FAIL rnd_result got r=%0d z=%b op=%0d want r=%0d z=%b op=%0d", out_r, out_zero, out_op, exp_q[0].r, exp_q[0].z, exp_q[0].op);
                    end
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_end got left=%0d v=%b want 0 0", exp_q.size(), out_valid); exp_q.delete(); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        n_checks++; if (ops_done !== 8'd0) begin n_fail++; $display("FAIL wrap_start got ops_done=%0d want 0", ops_done); end
        for (int c = 0; c < 300 && (sent < 260 || exp_q.size() > 0); c++) begin
            in_valid = (sent < 260);
            in_a = 4'($urandom); in_b = in_a; in_op = 3'd4;
            if (in_valid && in_ready) begin
                sent++;
                exp_q.push_back('{r: 4'd0, z: 1'b1, op: 3'd4});
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0 || {out_r, out_zero, out_op} !== exp_q[0]) begin
                    n_fail++; $display("FAIL wrap_result got r=%0d z=%b op=%0d want r=0 z=1 op=4", out_r, out_zero, out_op);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (sent != 260 || exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_stream got sent=%0d left=%0d want 260 0", sent, exp_q.size()); exp_q.delete(); end
        n_checks++; if (ops_done !== 8'd4) begin n_fail++; $display("FAIL wrap_ops_done got %0d want 4", ops_done); end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = 4'(i); in_op = 3'd4;
            tick();
        end
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ops_done !== 8'd0) begin
            n_fail++; $display("FAIL wrap_midreset got count=%0d v=%b in_ready=%b ops_done=%0d want 0 0 1 0", count, out_valid, in_ready, ops_done);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_after_reset got count=%0d v=%b want 0 0", count, out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_push_pop();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu4_issue_q.md
# alu4_issue_q

Operation queue and result stage wrapped around the combinational 4-bit ALU (`ALU4`). It accepts operand/opcode triples over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drives the FIFO head onto the ALU inputs and registers the ALU result and Zero flag into a single output slot, which it presents downstream over valid/ready. It decouples the producer of ALU operations from the consumer of results, and it counts completed operations.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  queue can accept; equals (count < DEPTH)
- in_a  in  4  operand A
- in_b  in  4  operand B
- in_op  in  3  ALU opcode, passed to the ALU unmodified
- alu_a  out  4  to ALU A; head entry's A, 0 when the queue is empty
- alu_b  out  4  to ALU B; head entry's B, 0 when the queue is empty
- alu_op  out  3  to ALU Op; head entry's opcode, 0 when the queue is empty
- alu_r  in  4  ALU result R (combinational from alu_*)
- alu_zero  in  1  ALU Zero flag
- out_valid  out  1  result slot holds a result
- out_ready  in  1  downstream accepts the result
- out_r  out  4  registered result
- out_zero  out  1  registered Zero flag
- out_op  out  3  opcode that produced out_r
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output slot
- ops_done  out  8  completed-result counter; wraps 255 -> 0

## Operation
- push = in_valid & in_ready. On push, {in_a, in_b, in_op} is written at the write pointer.
- slot_free = !out_valid | out_ready.
- pop = (count != 0) & slot_free. On pop:
  - alu_r, alu_zero and the head opcode load into out_r, out_zero and out_op.
  - out_valid is set.
  - The read pointer advances.
- out_valid & out_ready & !pop: out_valid clears. out_r, out_zero and out_op hold their last values.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- ops_done increments by 1 on every pop, modulo 256.
- in_ready is a function of registered count only. It has no combinational path from out_ready.
- When full, in_ready=0 and a pushing in_valid is ignored. A pop in that cycle does not make in_ready rise until the next cycle.
- Empty queue: alu_a, alu_b and alu_op are 0. No pop occurs and out_valid follows the handshake rules above.
- Output slot state machine:
  - EMPTY -> FULL on pop.
  - FULL -> FULL on pop & out_ready, or on !out_ready (hold).
  - FULL -> EMPTY on out_ready & !pop.
- The ALU result is sampled only on pop, at the same edge the head advances.

## Timing
- Reset (rst_n low at a rising edge) clears everything in that cycle; it overrides any simultaneous handshake:
  - in_ready=1, out_valid=0, out_r=0, out_zero=0, out_op=0
  - count=0, pointers=0, ops_done=0
  - alu_a, alu_b, alu_op = 0
- Reset mid-operation discards all queued entries and any pending result. No output handshake completes in the reset cycle.
- Latency: an operation pushed at edge N with an empty queue and a free slot is captured at edge N+1. out_valid=1 is visible after edge N+1. Minimum latency is 2 edges from in_valid assertion to the result.
- Throughput: 1 operation per cycle sustained while out_ready=1.
- Total buffering with out_ready held low is DEPTH+1 operations: DEPTH in the FIFO plus 1 in the output slot.
- out_valid, once asserted, stays high and out_r, out_zero and out_op stay stable until out_ready=1 is sampled.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> all outputs at their reset values, count=0, ops_done=0, no push recorded.
- Single op: push A=3, B=2, Op=000 into an idle block with out_ready=1 -> one edge later out_valid=1, out_r=5, out_zero=0, out_op=000, ops_done=1.
- Back-to-back: push Sub 5,5 / And 1010,0101 / Or 1000,0010 on consecutive cycles with out_ready=1 -> results appear on consecutive cycles in order:
  - out_r=0, out_zero=1
  - out_r=0, out_zero=1
  - out_r=10, out_zero=0
- Backpressure, DEPTH=4: out_ready=0, offer 7 ops -> exactly 5 accepted, in_ready=0 with count=4. out_valid=1 holds the first result unchanged. Raise out_ready -> all 5 results drain in order, then out_valid=0 and count=0.
- Simultaneous push/pop at full: with count=4, assert out_ready and in_valid -> the pop happens, the push is rejected that cycle, and in_ready=1 the following cycle.
- Wrap: stream 260 ops with Op=100, A=B -> pointers wrap with no loss, every out_zero=1, ops_done=4. Reset mid-stream -> count=0, out_valid=0 on the next cycle.
